// File: rtl/ps2_dev_tx_if.sv
// ps2_dev_tx_if: byte-write and PS/2 line bundle for ps2_dev_tx.
//   master: command-decoder / host side (drives wr, din, ovf_clr, ps2_clk_in)
//   slave : the transmitter (drives ps2_clk, ps2_data, busy, level, full, overflow)
// Signals:
//   wr, din[7:0]   byte push strobe and data
//   ovf_clr        clears the sticky overflow flag
//   ps2_clk_in     sensed PS/2 clock line, low = host inhibit (asynchronous)
//   ps2_clk        PS/2 clock toward the core
//   ps2_data       PS/2 data toward the core
//   busy           frame or inter-frame gap in progress
//   level[AW:0]    bytes held, including the one being sent
//   full           FIFO holds 2**AW bytes
//   overflow       sticky, a write was dropped
interface ps2_dev_tx_if #(
    parameter int unsigned AW = 3
);
    logic          wr;
    logic [7:0]    din;
    logic          ovf_clr;
    logic          ps2_clk_in;
    logic          ps2_clk;
    logic          ps2_data;
    logic          busy;
    logic [AW:0]   level;
    logic          full;
    logic          overflow;

    modport master (
        output wr, din, ovf_clr, ps2_clk_in,
        input  ps2_clk, ps2_data, busy, level, full, overflow
    );

    modport slave (
        input  wr, din, ovf_clr, ps2_clk_in,
        output ps2_clk, ps2_data, busy, level, full, overflow
    );
endinterface

// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: PS/2 device-side transmitter. Bytes pushed through the bus
// interface are queued in a 2**AW-deep FIFO and sent as 11-bit frames
// (start 0, d[0..7], odd parity, stop 1), each bit CLK_DIV cycles clock-high
// followed by CLK_DIV cycles clock-low, with GAP idle bit-times between frames.
// A low ps2_clk_in (host inhibit) blocks frame start and aborts a frame during
// any clock-high phase of bits 0..9; the byte stays queued and is resent whole.
// Ports:
//   clk_sys  system clock
//   reset    synchronous, active-high reset
//   bus      ps2_dev_tx_if slave modport (see interface header)
module ps2_dev_tx #(
    parameter int unsigned AW      = 3,
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned GAP     = 2
) (
    input logic          clk_sys,
    input logic          reset,
    ps2_dev_tx_if.slave  bus
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapTicks = 2 * GAP;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic          phase_q, phase_d;     // 0: clock-high phase, 1: clock-low phase
    logic [15:0]   gap_q, gap_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          clk_out_q, clk_out_d;
    logic          data_out_q, data_out_d;
    logic [7:0]    mem_q [Depth];
    logic [7:0]    mem_d [Depth];

    logic       inh;
    logic       tick;
    logic       pop;
    logic       push;
    logic       full;
    logic [7:0] head;

    // Wire value of frame bit idx for byte d.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
        logic b;
        if (idx == 4'd0) begin
            b = 1'b0;
        end else if (idx <= 4'd8) begin
            b = d[3'(idx - 4'd1)];
        end else if (idx == 4'd9) begin
            b = ~^d;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    assign inh  = ~sync2_q;
    assign tick = (div_q == DW'(CLK_DIV - 1));
    assign full = (count_q == (AW + 1)'(Depth));
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        sync1_d = bus.ps2_clk_in;
        sync2_d = sync1_q;
    end

    // Sequencer
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        pop     = 1'b0;

        if (state_q != StIdle) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (count_q != '0 && !inh) begin
                    state_d = StSend;
                    bit_d   = 4'd0;
                    phase_d = 1'b0;
                end
            end
            StSend: begin
                // Inhibit is honoured only while we are not pulling the clock low
                // ourselves; the stop bit always completes.
                if (!phase_q && inh && bit_q <= 4'd9) begin
                    state_d = StIdle;
                end else if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd10) begin
                        pop     = 1'b1;
                        phase_d = 1'b0;
                        bit_d   = 4'd0;
                        gap_d   = '0;
                        state_d = (GAP == 0) ? StIdle : StGap;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (gap_q == 16'(GapTicks - 1)) begin
                        state_d = StIdle;
                    end else begin
                        gap_d = gap_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            div_d = '0;
        end
    end

    // Line drivers are registered from the next state so they line up with state_q.
    always_comb begin
        clk_out_d  = !(state_d == StSend && phase_d);
        data_out_d = (state_d == StSend) ? frame_bit(bit_d, head) : 1'b1;
    end

    // FIFO; a write in the pop cycle is accepted even when full.
    always_comb begin
        push = bus.wr && (!full || pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.din;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (bus.wr && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= 4'd0;
            phase_q    <= 1'b0;
            gap_q      <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            clk_out_q  <= 1'b1;
            data_out_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            gap_q      <= gap_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            clk_out_q  <= clk_out_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage needs no reset: only entries behind the write pointer are read.
    always_ff @(posedge clk_sys) begin
        mem_q <= mem_d;
    end

    assign bus.ps2_clk  = clk_out_q;
    assign bus.ps2_data = data_out_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.level    = count_q;
    assign bus.full     = full;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb_ps2_dev_tx: directed/randomised bench for ps2_dev_tx (AW=3, CLK_DIV=4, GAP=2).
// A monitor records every falling edge of ps2_clk with the data level and cycle;
// captured frames are compared against a byte queue of expected transmissions.
module tb_ps2_dev_tx;

    localparam int unsigned AW      = 3;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned DEPTH   = 2 ** AW;
    localparam int unsigned BIT_T   = 2 * CLK_DIV;
    localparam int unsigned FRAME_T = 11 * BIT_T;
    localparam int unsigned GAP_T   = 2 * GAP * CLK_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ps2_dev_tx_if #(.AW(AW)) bus ();

    ps2_dev_tx #(
        .AW      (AW),
        .CLK_DIV (CLK_DIV),
        .GAP     (GAP)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic        prev_clk = 1'b1;
    logic        bits_q[$];
    longint      times_q[$];
    logic [7:0]  exp_q[$];
    int          lvl_trace[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_clk === 1'b1 && bus.ps2_clk === 1'b0) begin
            bits_q.push_back(bus.ps2_data);
            times_q.push_back(cyc);
        end
        prev_clk = bus.ps2_clk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        step();
        bus.wr  = 1'b1;
        bus.din = b;
        step();
        bus.wr  = 1'b0;
    endtask

    task automatic run_until_empty(input int budget, output int busy_cyc);
        bit done;
        int last;
        done     = 1'b0;
        last     = int'(bus.level);
        busy_cyc = 0;
        lvl_trace.delete();
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (bus.busy) busy_cyc++;
            if (int'(bus.level) != last) begin
                last = int'(bus.level);
                lvl_trace.push_back(last);
            end
            if (bus.level == '0 && !bus.busy) done = 1'b1;
        end
        check("run_done", 64'(done), 64'd1);
    endtask

    task automatic wait_bits(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (bits_q.size() < n && i < budget) begin
            step();
            i++;
        end
        check({tag, "_wait"}, 64'(bits_q.size() >= n), 64'd1);
    endtask

    // Compares captured edges with the next n expected bytes, then clears capture.
    task automatic check_frames(input int n, input string tag);
        logic [7:0]  b;
        logic [10:0] want;
        logic [10:0] got;
        int          bad;
        check({tag, "_nbits"}, 64'(bits_q.size()), 64'(11 * n));
        for (int k = 0; k < n; k++) begin
            if (bits_q.size() < 11 * (k + 1)) break;
            b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            want = {1'b1, ~^b, b, 1'b0};
            bad  = 0;
            for (int i = 0; i < 11; i++) begin
                got[i] = bits_q[11 * k + i];
                if (i < 10 && times_q[11 * k + i + 1] - times_q[11 * k + i] != longint'(BIT_T))
                    bad++;
            end
            check({tag, "_frame"}, 64'(got), 64'(want));
            check({tag, "_spacing"}, 64'(bad), 64'd0);
        end
        bits_q.delete();
        times_q.delete();
    endtask

    initial begin
        int         bc;
        int         n0;
        longint     gap;
        logic [7:0] b;

        bus.wr         = 1'b0;
        bus.din        = 8'h00;
        bus.ovf_clr    = 1'b0;
        bus.ps2_clk_in = 1'b1;
        reset          = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_clk", 64'(bus.ps2_clk), 64'd1);
        check("rst_data", 64'(bus.ps2_data), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        reset = 1'b0;
        repeat (3) step();
        bits_q.delete();
        times_q.delete();

        // Single byte 0x1C
        exp_q.push_back(8'h1C);
        write_byte(8'h1C);
        check("t1_level", 64'(bus.level), 64'd1);
        run_until_empty(400, bc);
        check("t1_busy_cycles", 64'(bc), 64'(FRAME_T + GAP_T));
        check("t1_lvl_steps", 64'(lvl_trace.size()), 64'd1);
        check_frames(1, "t1");

        // 0x00 then 0xFF: parity 1 both, level 2,1,0, idle gap between frames
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        write_byte(8'h00);
        write_byte(8'hFF);
        check("t2_level", 64'(bus.level), 64'd2);
        run_until_empty(600, bc);
        check("t2_lvl_steps", 64'(lvl_trace.size()), 64'd2);
        if (lvl_trace.size() == 2) begin
            check("t2_lvl_first", 64'(lvl_trace[0]), 64'd1);
            check("t2_lvl_second", 64'(lvl_trace[1]), 64'd0);
        end
        gap = (times_q.size() >= 12) ? times_q[11] - times_q[10] : 0;
        check("t2_frame_gap", 64'(gap >= longint'(BIT_T + GAP_T) &&
                                  gap <= longint'(BIT_T + GAP_T + 3)), 64'd1);
        check_frames(2, "t2");

        // Random bytes
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
        end
        run_until_empty(1000, bc);
        check_frames(4, "rand");

        // Overflow while inhibited
        bus.ps2_clk_in = 1'b0;
        repeat (4) step();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b);
            write_byte(b);
        end
        check("t3_level", 64'(bus.level), 64'(DEPTH));
        check("t3_full", 64'(bus.full), 64'd1);
        check("t3_ovf", 64'(bus.overflow), 64'd1);
        check("t3_busy", 64'(bus.busy), 64'd0);
        check("t3_no_edges", 64'(bits_q.size()), 64'd0);
        step();
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        check("t3_ovf_clr", 64'(bus.overflow), 64'd0);
        bus.ps2_clk_in = 1'b1;
        run_until_empty(1200, bc);
        check_frames(DEPTH, "t3");

        // Abort during bit-4 clock-high phase, then resend
        b = 8'($urandom);
        exp_q.push_back(b);
        write_byte(b);
        wait_bits(4, 200, "t4_bit4");
        for (int i = 0; i < 20 && bus.ps2_clk !== 1'b1; i++) step();
        bus.ps2_clk_in = 1'b0;
        repeat (3) step();
        check("t4_abort_clk", 64'(bus.ps2_clk), 64'd1);
        check("t4_abort_data", 64'(bus.ps2_data), 64'd1);
        repeat (20) step();
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_level", 64'(bus.level), 64'd1);
        check("t4_partial_edges", 64'(bits_q.size()), 64'd4);
        bits_q.delete();
        times_q.delete();
        bus.ps2_clk_in = 1'b1;
        run_until_empty(400, bc);
        check_frames(1, "t4");

        // Full FIFO, write lands in the frame-completion pop cycle
        bus.ps2_clk_in = 1'b0;
        repeat (4) step();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            write_byte(b);
        end
        check("t5_full", 64'(bus.full), 64'd1);
        bus.ps2_clk_in = 1'b1;
        wait_bits(11, 300, "t5_stop");
        // Stop-bit low phase lasts CLK_DIV cycles; the pop is at its end.
        repeat (CLK_DIV - 1) step();
        b = 8'($urandom);
        exp_q.push_back(b);
        bus.wr  = 1'b1;
        bus.din = b;
        step();
        bus.wr  = 1'b0;
        check("t5_level", 64'(bus.level), 64'(DEPTH));
        check("t5_ovf", 64'(bus.overflow), 64'd0);
        check("t5_full_after", 64'(bus.full), 64'd1);
        run_until_empty(1300, bc);
        check_frames(DEPTH + 1, "t5");

        // Reset during bit 6
        b = 8'($urandom);
        write_byte(b);
        wait_bits(7, 200, "t6_bit6");
        reset = 1'b1;
        step();
        check("t6_clk", 64'(bus.ps2_clk), 64'd1);
        check("t6_data", 64'(bus.ps2_data), 64'd1);
        check("t6_level", 64'(bus.level), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        n0 = bits_q.size();
        repeat (40) step();
        check("t6_no_edges", 64'(bits_q.size()), 64'(n0));
        check("t6_ovf", 64'(bus.overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
